// File: rtl/mult_batch_pkg.sv
// Shared types and constants for the batch multiplier engine.
package mult_batch_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_CW    = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INPUT  = 2'd1,
        S_EXEC   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    // Ceiling log2, usable in constant expressions for pointer widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = unsigned'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_batch_engine_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous flush and
// first-word-fall-through read data.
module sync_fifo
    import mult_batch_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic                    WR,
    input  logic                    RD,
    input  logic [WIDTH-1:0]        DIN,
    output logic [WIDTH-1:0]        DOUT,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [clog2(DEPTH):0]   COUNT
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = WR & ~FULL & ~CLR;
    assign rd_en = RD & ~EMPTY & ~CLR;

    assign EMPTY = (wr_ptr == rd_ptr);
    assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign COUNT = wr_ptr - rd_ptr;
    assign DOUT  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= DIN;
    end

endmodule

// File: rtl/mult_batch_engine.sv
// Batch multiplier engine: collect DEPTH operand pairs, multiply, drain products.
// Define MULT_BATCH_SIGNED_EN for two's-complement operands (default: unsigned).
module mult_batch_engine
    import mult_batch_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            HALT,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic            ACK,
    output logic            REQ_AB,
    output logic [2*DW-1:0] X,
    output logic            X_VALID,
    input  logic            X_RDY,
    output logic            BUSY,
    output logic            DONE,
    output logic            OVER,
    output logic [CW-1:0]   BATCH_CNT
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned NW = AW + 1;
    localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);
    localparam logic [NW-1:0] CNT_LAST = NW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;

    logic          fifo_clr;
    logic          in_wr;
    logic          in_rd;
    logic          in_full;
    logic          in_empty;
    logic [NW-1:0] in_count;
    logic [PW-1:0] in_dout;

    logic          out_wr;
    logic          out_rd;
    logic          out_full;
    logic          out_empty;
    logic [NW-1:0] out_count;
    logic [PW-1:0] out_dout;

    logic          stg_valid;
    logic [PW-1:0] stg_x;
    logic [PW-1:0] op_a_ext;
    logic [PW-1:0] op_b_ext;
    logic [PW-1:0] prod_c;

    logic          accept_c;
    logic          load_c;
    logic          last_accept_c;
    logic          drop_c;
    logic          halt_c;

    assign REQ_AB = (state == S_INPUT) & ~in_full & ~ACK;

    sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_in_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (fifo_clr),
        .WR    (in_wr),
        .RD    (in_rd),
        .DIN   ({A, B}),
        .DOUT  (in_dout),
        .FULL  (in_full),
        .EMPTY (in_empty),
        .COUNT (in_count)
    );

    sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_out_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (fifo_clr),
        .WR    (out_wr),
        .RD    (out_rd),
        .DIN   (stg_x),
        .DOUT  (out_dout),
        .FULL  (out_full),
        .EMPTY (out_empty),
        .COUNT (out_count)
    );

    // Operands widened to the product width so one multiply serves both modes.
    always_comb begin
`ifdef MULT_BATCH_SIGNED_EN
        op_a_ext = {{DW{in_dout[PW-1]}}, in_dout[PW-1:DW]};
        op_b_ext = {{DW{in_dout[DW-1]}}, in_dout[DW-1:0]};
`else
        op_a_ext = {{DW{1'b0}}, in_dout[PW-1:DW]};
        op_b_ext = {{DW{1'b0}}, in_dout[DW-1:0]};
`endif
        prod_c = op_a_ext * op_b_ext;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle datapath strobes; HALT overrides everything last.
    always_comb begin
        state_nxt     = state;
        fifo_clr      = 1'b0;
        in_wr         = 1'b0;
        in_rd         = 1'b0;
        out_wr        = 1'b0;
        out_rd        = 1'b0;
        load_c        = 1'b0;
        last_accept_c = 1'b0;
        accept_c      = X_VALID & X_RDY;
        drop_c        = ACK & ((state != S_INPUT) | in_full);
        halt_c        = HALT & (state != S_IDLE);

        case (state)
            S_IDLE: begin
                fifo_clr = 1'b1;
                if (START) state_nxt = S_INPUT;
            end
            S_INPUT: begin
                in_wr = ACK & ~in_full;
                if (in_count == CNT_FULL) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // Reserve a slot for the product still sitting in the stage.
                in_rd  = ~in_empty & ((out_count + NW'(stg_valid)) < CNT_FULL);
                out_wr = stg_valid;
                if (out_full | ((out_count == CNT_LAST) & stg_valid)) state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                load_c = ~out_empty & (~X_VALID | X_RDY);
                out_rd = load_c;
                if (accept_c & out_empty) begin
                    last_accept_c = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (halt_c) begin
            state_nxt     = S_IDLE;
            fifo_clr      = 1'b1;
            in_wr         = 1'b0;
            in_rd         = 1'b0;
            out_wr        = 1'b0;
            out_rd        = 1'b0;
            load_c        = 1'b0;
            last_accept_c = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stg_valid <= 1'b0;
            stg_x     <= '0;
            X         <= '0;
            X_VALID   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVER      <= 1'b0;
            BATCH_CNT <= '0;
        end else begin
            stg_valid <= in_rd;
            if (in_rd) stg_x <= prod_c;

            if (halt_c) begin
                X_VALID <= 1'b0;
            end else if (load_c) begin
                X       <= out_dout;
                X_VALID <= 1'b1;
            end else if (accept_c) begin
                X_VALID <= 1'b0;
            end

            BUSY <= (state_nxt != S_IDLE);
            DONE <= last_accept_c;
            if (drop_c)        OVER      <= 1'b1;
            if (last_accept_c) BATCH_CNT <= BATCH_CNT + CW'(1);
        end
    end

endmodule

// File: tb/tb_mult_batch_engine.sv
// Scoreboard bench for mult_batch_engine: randomized batches against an
// arithmetic reference, with backpressure, HALT, overflow, async reset and wrap.
module tb_mult_batch_engine;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int PW    = 2 * DW;

`ifdef MULT_BATCH_SIGNED_EN
    localparam logic [PW-1:0] EXP_FF_FF = 16'h0001;
`else
    localparam logic [PW-1:0] EXP_FF_FF = 16'hFE01;
`endif

    logic          CLK;
    logic          RST;
    logic          START;
    logic          HALT;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          ACK;
    logic          REQ_AB;
    logic [PW-1:0] X;
    logic          X_VALID;
    logic          X_RDY;
    logic          BUSY;
    logic          DONE;
    logic          OVER;
    logic [CW-1:0] BATCH_CNT;

    mult_batch_engine #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .HALT      (HALT),
        .A         (A),
        .B         (B),
        .ACK       (ACK),
        .REQ_AB    (REQ_AB),
        .X         (X),
        .X_VALID   (X_VALID),
        .X_RDY     (X_RDY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVER      (OVER),
        .BATCH_CNT (BATCH_CNT)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    logic [PW-1:0] exp_q[$];
    int            acc_cnt = 0;
    bit            pend_done = 0;
    int            exp_batches = 0;
    bit            hold_prev = 0;
    logic [PW-1:0] hold_x = '0;
    logic [PW-1:0] first_x = '0;
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    logic [DW-1:0] pa [DEPTH];
    logic [DW-1:0] pb [DEPTH];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expire(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
`ifdef MULT_BATCH_SIGNED_EN
        if (sa >= (longint'(1) << (DW - 1))) sa = sa - (longint'(1) << DW);
        if (sb >= (longint'(1) << (DW - 1))) sb = sb - (longint'(1) << DW);
`endif
        return PW'(sa * sb);
    endfunction

    // Consumer ready pattern, changed just after each rising edge.
    initial begin
        X_RDY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: X_RDY = 1'b1;
                1: begin
                    X_RDY = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
                    rdy_ph++;
                end
                2: X_RDY = 1'b0;
                default: X_RDY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, tracks DONE and hold stability.
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (pend_done || DONE) begin
                    chk("done_pulse", longint'(DONE), longint'(pend_done));
                    if (pend_done) exp_batches++;
                    pend_done = 0;
                end
                if (hold_prev && X_VALID) chk("x_stable", longint'(X), longint'(hold_x));
                if (X_VALID && X_RDY) begin
                    if (exp_q.size() == 0) begin
                        chk("x_unexpected", longint'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (acc_cnt == 0) first_x = X;
                        chk("x_value", longint'(X), longint'(e));
                        acc_cnt++;
                        if (acc_cnt == DEPTH) begin
                            pend_done = 1;
                            acc_cnt   = 0;
                        end
                    end
                end
                hold_prev = X_VALID && !X_RDY;
                hold_x    = X;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start_batch();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("busy_after_start", longint'(BUSY), 1);
    endtask

    task automatic feed();
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < DEPTH && guard < 200) begin
            @(negedge CLK);
            ACK = 1'b0;
            #1;
            if (REQ_AB) begin
                A   = pa[i];
                B   = pb[i];
                ACK = 1'b1;
                exp_q.push_back(ref_mul(pa[i], pb[i]));
                i++;
            end
            guard++;
        end
        if (i < DEPTH) expire("feed_timeout");
        @(negedge CLK);
        ACK = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge CLK);
        while (BUSY && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (BUSY) expire("idle_timeout");
        @(negedge CLK);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            pa[i] = DW'($urandom);
            pb[i] = DW'($urandom);
        end
    endtask

    task automatic run_batch(input int mode);
        rdy_mode = mode;
        start_batch();
        feed();
        wait_idle();
        chk("batch_cnt", longint'(BATCH_CNT), longint'(exp_batches % (1 << CW)));
        chk("queue_drained", longint'(exp_q.size()), 0);
        chk("busy_idle", longint'(BUSY), 0);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        HALT  = 1'b0;
        ACK   = 1'b0;
        A     = '0;
        B     = '0;

        // Reset state
        #12;
        chk("rst_req_ab", longint'(REQ_AB), 0);
        chk("rst_x", longint'(X), 0);
        chk("rst_x_valid", longint'(X_VALID), 0);
        chk("rst_busy", longint'(BUSY), 0);
        chk("rst_done", longint'(DONE), 0);
        chk("rst_over", longint'(OVER), 0);
        chk("rst_batch_cnt", longint'(BATCH_CNT), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Nominal batch (i+1)*(i+2)
        for (int i = 0; i < DEPTH; i++) begin
            pa[i] = DW'(i + 1);
            pb[i] = DW'(i + 2);
        end
        run_batch(0);
        chk("nominal_over", longint'(OVER), 0);

        // Backpressure 1,0,0,1
        rdy_ph = 0;
        run_batch(1);

        // Random data with random backpressure
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_batch(3);
        end

        // Extremes
        for (int i = 0; i < DEPTH; i++) begin
            pa[i] = 8'hFF;
            pb[i] = (i % 2 == 0) ? 8'hFF : 8'h02;
        end
        run_batch(0);
        chk("extreme_ff_ff", longint'(first_x), longint'(EXP_FF_FF));

        // HALT in the middle of execution
        for (int i = 0; i < DEPTH; i++) begin
            pa[i] = DW'(i + 1);
            pb[i] = DW'(i + 2);
        end
        rdy_mode = 0;
        start_batch();
        feed();
        tick(4);
        @(negedge CLK);
        HALT = 1'b1;
        @(negedge CLK);
        HALT = 1'b0;
        chk("halt_x_valid", longint'(X_VALID), 0);
        chk("halt_busy", longint'(BUSY), 0);
        chk("halt_batch_cnt", longint'(BATCH_CNT), longint'(exp_batches % (1 << CW)));
        exp_q.delete();
        acc_cnt = 0;
        tick(3);
        fill_random();
        run_batch(0);

        // Overflow: ACK held for DEPTH+2 cycles
        rdy_mode = 0;
        start_batch();
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge CLK);
            ACK = 1'b0;
            #1;
            chk("ovf_req_ab", longint'(REQ_AB), longint'(i < DEPTH));
            A   = DW'($urandom);
            B   = DW'($urandom);
            ACK = 1'b1;
            if (i < DEPTH) exp_q.push_back(ref_mul(A, B));
        end
        @(negedge CLK);
        ACK = 1'b0;
        chk("ovf_over_set", longint'(OVER), 1);
        wait_idle();
        chk("ovf_batch_cnt", longint'(BATCH_CNT), longint'(exp_batches % (1 << CW)));
        fill_random();
        run_batch(0);
        chk("ovf_over_sticky", longint'(OVER), 1);

        // Async reset while holding a product in S_OUTPUT
        fill_random();
        rdy_mode = 2;
        start_batch();
        feed();
        begin
            int guard;
            guard = 0;
            while (!X_VALID && guard < 100) begin
                @(negedge CLK);
                guard++;
            end
            if (!X_VALID) expire("output_timeout");
        end
        tick(2);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_x", longint'(X), 0);
        chk("arst_x_valid", longint'(X_VALID), 0);
        chk("arst_busy", longint'(BUSY), 0);
        chk("arst_over", longint'(OVER), 0);
        chk("arst_batch_cnt", longint'(BATCH_CNT), 0);
        chk("arst_req_ab", longint'(REQ_AB), 0);
        #1;
        RST = 1'b0;
        exp_q.delete();
        acc_cnt     = 0;
        pend_done   = 0;
        exp_batches = 0;
        hold_prev   = 0;
        rdy_mode    = 0;

        // BATCH_CNT wrap 255 -> 0
        for (int k = 0; k < (1 << CW); k++) begin
            fill_random();
            run_batch((k % 4 == 0) ? 3 : 0);
        end
        chk("cnt_wrap", longint'(BATCH_CNT), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
